// File: rtl/resolver_peak_monitor_pkg.sv
// ---------------------------------------------------------------------------
// resolver_peak_monitor_pkg
// Shared types and constants for the resolver peak monitor.
//   state_t     : window sequencer states
//   SAMPLE_MAX  : largest signed ADC code (also the neutral running minimum)
//   SAMPLE_MIN  : smallest signed ADC code (also the neutral running maximum)
//   clamp_len() : window length with 0 and 1 promoted to 2
// ---------------------------------------------------------------------------
package resolver_peak_monitor_pkg;

    localparam int ADC_RESOLUTION_DFLT = 14;
    localparam int SAMPLE_MAX = (2 ** (ADC_RESOLUTION_DFLT - 1)) - 1;
    localparam int SAMPLE_MIN = -(2 ** (ADC_RESOLUTION_DFLT - 1));

    typedef enum logic {
        WAIT_START = 1'b0,
        ACCUM      = 1'b1
    } state_t;

    // A window needs at least two samples to describe a peak-to-peak span.
    function automatic logic [31:0] clamp_len(input logic [31:0] len);
        return (len < 32'd2) ? 32'd2 : len;
    endfunction

endpackage

// File: rtl/resolver_peak_monitor_tracker.sv
// ---------------------------------------------------------------------------
// peak_tracker
// One channel of the peak monitor: running signed max/min over a window.
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   clear_i          : force running extrema neutral (highest priority)
//   seed_i           : first sample of a window, load max = min = sample
//   update_i         : mid-window sample, fold into running extrema
//   close_i          : final sample, fold in, publish result, go neutral
//   sample_i         : signed two's-complement sample
//   max_o, min_o     : published window extrema (registered)
//   amp_next_o       : (max - min) >> 1 of the window being closed
//                      (combinational, valid in the close_i cycle)
// ---------------------------------------------------------------------------
module peak_tracker
    import resolver_peak_monitor_pkg::*;
#(
    parameter int W = ADC_RESOLUTION_DFLT
) (
    input  logic         clk_i,
    input  logic         reset_n_i,
    input  logic         clear_i,
    input  logic         seed_i,
    input  logic         update_i,
    input  logic         close_i,
    input  logic [W-1:0] sample_i,
    output logic [W-1:0] max_o,
    output logic [W-1:0] min_o,
    output logic [W-1:0] amp_next_o
);

    // Neutral extrema: any real sample replaces them on the first compare.
    localparam logic signed [W-1:0] NEUTRAL_MAX = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] NEUTRAL_MIN = {1'b0, {(W-1){1'b1}}};

    logic signed [W-1:0] sample;
    logic signed [W-1:0] run_max;
    logic signed [W-1:0] run_min;
    logic signed [W-1:0] cand_max;
    logic signed [W-1:0] cand_min;
    logic        [W:0]   span;

    assign sample   = sample_i;
    assign cand_max = (sample > run_max) ? sample : run_max;
    assign cand_min = (sample < run_min) ? sample : run_min;

    // Sign-extend to W+1 bits so full-scale span cannot overflow; max >= min
    // always holds here, so the span is non-negative.
    assign span       = {cand_max[W-1], cand_max} - {cand_min[W-1], cand_min};
    assign amp_next_o = W'(span >> 1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            run_max <= NEUTRAL_MAX;
            run_min <= NEUTRAL_MIN;
            max_o   <= '0;
            min_o   <= '0;
        end else if (clear_i) begin
            run_max <= NEUTRAL_MAX;
            run_min <= NEUTRAL_MIN;
        end else if (seed_i) begin
            run_max <= sample;
            run_min <= sample;
        end else if (close_i) begin
            max_o   <= cand_max;
            min_o   <= cand_min;
            run_max <= NEUTRAL_MAX;
            run_min <= NEUTRAL_MIN;
        end else if (update_i) begin
            run_max <= cand_max;
            run_min <= cand_min;
        end
    end

endmodule

// File: rtl/resolver_peak_monitor.sv
// ---------------------------------------------------------------------------
// resolver_peak_monitor
// Per-window max/min and peak-to-peak amplitude of the raw sin/cos samples.
//   clk_i, reset_n_i        : clock, asynchronous active-low reset
//   sample_valid_i          : qualifies sin_i / cos_i
//   sin_i, cos_i            : signed ADC samples
//   window_len_i            : samples per window, taken at window start
//   clear_i                 : abort window, discard partial extrema
//   sin/cos_max_o, _min_o   : signed window extrema
//   sin_amp_o, cos_amp_o    : (max - min) >> 1
//   amp_delta_o             : |sin_amp - cos_amp|, only with PEAK_MISMATCH_EN
//   peak_valid_o            : one-cycle strobe, all results updated
// Optional feature macro: PEAK_MISMATCH_EN (undefined: amp_delta_o = 0).
// ---------------------------------------------------------------------------
module resolver_peak_monitor
    import resolver_peak_monitor_pkg::*;
#(
    parameter int ADC_RESOLUTION = 14,
    parameter int WINDOW_WIDTH   = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      sample_valid_i,
    input  logic [ADC_RESOLUTION-1:0] sin_i,
    input  logic [ADC_RESOLUTION-1:0] cos_i,
    input  logic [WINDOW_WIDTH-1:0]   window_len_i,
    input  logic                      clear_i,
    output logic [ADC_RESOLUTION-1:0] sin_max_o,
    output logic [ADC_RESOLUTION-1:0] sin_min_o,
    output logic [ADC_RESOLUTION-1:0] cos_max_o,
    output logic [ADC_RESOLUTION-1:0] cos_min_o,
    output logic [ADC_RESOLUTION-1:0] sin_amp_o,
    output logic [ADC_RESOLUTION-1:0] cos_amp_o,
    output logic [ADC_RESOLUTION-1:0] amp_delta_o,
    output logic                      peak_valid_o
);

    state_t                    state;
    logic [WINDOW_WIDTH-1:0]   count;
    logic [WINDOW_WIDTH-1:0]   len_q;
    logic [WINDOW_WIDTH-1:0]   len_next;
    logic                      accept;
    logic                      last;
    logic                      seed;
    logic                      update;
    logic                      close;
    logic [ADC_RESOLUTION-1:0] sin_amp_next;
    logic [ADC_RESOLUTION-1:0] cos_amp_next;

    // clear_i wins over a coincident sample.
    assign accept   = sample_valid_i && !clear_i;
    assign last     = (state == ACCUM) && (count == len_q - WINDOW_WIDTH'(1));
    assign seed     = accept && (state == WAIT_START);
    assign close    = accept && last;
    assign update   = accept && (state == ACCUM) && !last;
    assign len_next = WINDOW_WIDTH'(clamp_len(32'(window_len_i)));

    peak_tracker #(.W(ADC_RESOLUTION)) u_sin (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .clear_i    (clear_i),
        .seed_i     (seed),
        .update_i   (update),
        .close_i    (close),
        .sample_i   (sin_i),
        .max_o      (sin_max_o),
        .min_o      (sin_min_o),
        .amp_next_o (sin_amp_next)
    );

    peak_tracker #(.W(ADC_RESOLUTION)) u_cos (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .clear_i    (clear_i),
        .seed_i     (seed),
        .update_i   (update),
        .close_i    (close),
        .sample_i   (cos_i),
        .max_o      (cos_max_o),
        .min_o      (cos_min_o),
        .amp_next_o (cos_amp_next)
    );

    // Window sequencer. The closing edge relatches the length and restarts
    // the count at 0 while staying in ACCUM, so the next sample is never lost.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state        <= WAIT_START;
            count        <= '0;
            len_q        <= '0;
            peak_valid_o <= 1'b0;
            sin_amp_o    <= '0;
            cos_amp_o    <= '0;
        end else begin
            peak_valid_o <= 1'b0;
            if (clear_i) begin
                state <= WAIT_START;
                count <= '0;
            end else if (seed) begin
                len_q <= len_next;
                count <= WINDOW_WIDTH'(1);
                state <= ACCUM;
            end else if (close) begin
                len_q        <= len_next;
                count        <= '0;
                peak_valid_o <= 1'b1;
                sin_amp_o    <= sin_amp_next;
                cos_amp_o    <= cos_amp_next;
            end else if (update) begin
                count <= count + WINDOW_WIDTH'(1);
            end
        end
    end

`ifdef PEAK_MISMATCH_EN
    logic [ADC_RESOLUTION:0] amp_diff;
    logic [ADC_RESOLUTION:0] amp_abs;

    assign amp_diff = {1'b0, sin_amp_next} - {1'b0, cos_amp_next};
    assign amp_abs  = amp_diff[ADC_RESOLUTION] ? (~amp_diff + 1'b1) : amp_diff;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            amp_delta_o <= '0;
        end else if (close) begin
            amp_delta_o <= amp_abs[ADC_RESOLUTION] ? {ADC_RESOLUTION{1'b1}}
                                                   : amp_abs[ADC_RESOLUTION-1:0];
        end
    end
`else
    assign amp_delta_o = '0;
`endif

endmodule

// File: tb/tb_resolver_peak_monitor.sv
module tb_resolver_peak_monitor;
    import resolver_peak_monitor_pkg::*;

    typedef struct packed {
        logic [13:0] smax;
        logic [13:0] smin;
        logic [13:0] cmax;
        logic [13:0] cmin;
        logic [13:0] samp;
        logic [13:0] camp;
        logic [13:0] delta;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [13:0] sin_s = '0;
    logic [13:0] cos_s = '0;
    logic [15:0] window_len = 16'd4;
    logic        clear = 1'b0;
    logic [13:0] sin_max, sin_min, cos_max, cos_min, sin_amp, cos_amp, amp_delta;
    logic        peak_valid;

    int   checks = 0;
    int   errors = 0;
    int   strobe_count = 0;
    logic strobe_due = 1'b0;
    exp_t exp_q[$];
    exp_t last_exp = '0;

    // Reference model state
    int m_state = 0;
    int m_cnt = 0;
    int m_len = 2;
    int m_smax, m_smin, m_cmax, m_cmin;

    resolver_peak_monitor dut (
        .clk_i          (clk),
        .reset_n_i      (rst_n),
        .sample_valid_i (sample_valid),
        .sin_i          (sin_s),
        .cos_i          (cos_s),
        .window_len_i   (window_len),
        .clear_i        (clear),
        .sin_max_o      (sin_max),
        .sin_min_o      (sin_min),
        .cos_max_o      (cos_max),
        .cos_min_o      (cos_min),
        .sin_amp_o      (sin_amp),
        .cos_amp_o      (cos_amp),
        .amp_delta_o    (amp_delta),
        .peak_valid_o   (peak_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int tb_clamp(input logic [15:0] l);
        return (l < 16'd2) ? 2 : int'(l);
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_cnt   = 0;
        m_smax  = SAMPLE_MIN;
        m_smin  = SAMPLE_MAX;
        m_cmax  = SAMPLE_MIN;
        m_cmin  = SAMPLE_MAX;
    endtask

    // One clock of stimulus; the model predicts what the DUT accepts on the
    // coming edge and queues the window result when that sample is the last.
    task automatic cycle(input logic v, input int s, input int c, input logic clr);
        logic fin;
        exp_t e;
        int   sa, ca, d;
        fin = 1'b0;
        sample_valid = v;
        sin_s = 14'(s);
        cos_s = 14'(c);
        clear = clr;
        if (rst_n) begin
            if (clr) begin
                model_reset();
            end else if (v) begin
                if (m_state == 0) begin
                    m_len = tb_clamp(window_len);
                    m_smax = s; m_smin = s; m_cmax = c; m_cmin = c;
                    m_cnt = 1;
                    m_state = 1;
                end else begin
                    if (s > m_smax) m_smax = s;
                    if (s < m_smin) m_smin = s;
                    if (c > m_cmax) m_cmax = c;
                    if (c < m_cmin) m_cmin = c;
                    if (m_cnt == m_len - 1) begin
                        sa = (m_smax - m_smin) / 2;
                        ca = (m_cmax - m_cmin) / 2;
`ifdef PEAK_MISMATCH_EN
                        d = (sa > ca) ? sa - ca : ca - sa;
`else
                        d = 0;
`endif
                        e = '{14'(m_smax), 14'(m_smin), 14'(m_cmax), 14'(m_cmin),
                              14'(sa), 14'(ca), 14'(d)};
                        exp_q.push_back(e);
                        last_exp = e;
                        fin = 1'b1;
                        m_len = tb_clamp(window_len);
                        model_reset();
                        m_state = 1;
                    end else begin
                        m_cnt++;
                    end
                end
            end
        end
        @(posedge clk);
        strobe_due = fin;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 1'b0);
    endtask

    // Scoreboard monitor: strobe timing every cycle, results on each strobe.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            checks++;
            if (peak_valid !== strobe_due) begin
                errors++;
                $display("FAIL strobe_timing: peak_valid_o=%b required %b at %0t",
                         peak_valid, strobe_due, $time);
            end
            if (peak_valid === 1'b1) strobe_count++;
            if (strobe_due) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty: strobe expected with no queued result");
                end else begin
                    e = exp_q.pop_front();
                    if ({sin_max, sin_min, cos_max, cos_min, sin_amp, cos_amp, amp_delta} !== e) begin
                        errors++;
                        $display("FAIL window_result: got smax=%0d smin=%0d cmax=%0d cmin=%0d samp=%0d camp=%0d delta=%0d required smax=%0d smin=%0d cmax=%0d cmin=%0d samp=%0d camp=%0d delta=%0d",
                                 $signed(sin_max), $signed(sin_min), $signed(cos_max), $signed(cos_min),
                                 sin_amp, cos_amp, amp_delta,
                                 $signed(e.smax), $signed(e.smin), $signed(e.cmax), $signed(e.cmin),
                                 e.samp, e.camp, e.delta);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        idle(2);
        checks++;
        if ({sin_max, sin_min, cos_max, cos_min, sin_amp, cos_amp, amp_delta, peak_valid} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0",
                     {sin_max, sin_min, cos_max, cos_min, sin_amp, cos_amp, amp_delta, peak_valid});
        end
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_constant();
        window_len = 16'd4;
        for (int i = 0; i < 4; i++) cycle(1'b1, 4096, -4096, 1'b0);
        checks++;
        if ({peak_valid, sin_max, sin_min, sin_amp} !== {1'b1, 14'd4096, 14'd4096, 14'd0}) begin
            errors++;
            $display("FAIL constant_sin: got valid=%b max=%0d min=%0d amp=%0d required 1 4096 4096 0",
                     peak_valid, $signed(sin_max), $signed(sin_min), sin_amp);
        end
        checks++;
        if ({cos_max, cos_min, cos_amp} !== {14'h3000, 14'h3000, 14'd0}) begin
            errors++;
            $display("FAIL constant_cos: got max=%0d min=%0d amp=%0d required -4096 -4096 0",
                     $signed(cos_max), $signed(cos_min), cos_amp);
        end
        idle(1);
    endtask

    task automatic test_full_scale();
        int seq[6] = '{0, 8191, -8192, 100, -100, 5};
        cycle(1'b0, 0, 0, 1'b1);
        window_len = 16'd6;
        for (int i = 0; i < 6; i++) cycle(1'b1, seq[i], -seq[5-i] / 2, 1'b0);
        checks++;
        if ({sin_max, sin_min, sin_amp} !== {14'h1FFF, 14'h2000, 14'h1FFF}) begin
            errors++;
            $display("FAIL full_scale: got max=%0d min=%0d amp=%0d required 8191 -8192 8191",
                     $signed(sin_max), $signed(sin_min), sin_amp);
        end
        for (int i = 0; i < 6; i++) cycle(1'b1, 10, 10, 1'b0);
        checks++;
        if ({sin_max, sin_min, sin_amp, cos_max, cos_min} !== {14'd10, 14'd10, 14'd0, 14'd10, 14'd10}) begin
            errors++;
            $display("FAIL fresh_window: got max=%0d min=%0d amp=%0d required 10 10 0",
                     $signed(sin_max), $signed(sin_min), sin_amp);
        end
        idle(1);
    endtask

    task automatic test_short_len();
        int s0;
        cycle(1'b0, 0, 0, 1'b1);
        window_len = 16'd0;
        s0 = strobe_count;
        for (int i = 0; i < 4; i++) cycle(1'b1, i * 3, -i, 1'b0);
        window_len = 16'd1;
        for (int i = 0; i < 4; i++) cycle(1'b1, -i * 7, i, 1'b0);
        idle(1);
        checks++;
        if (strobe_count - s0 != 4) begin
            errors++;
            $display("FAIL short_len_strobes: got %0d required 4", strobe_count - s0);
        end
    endtask

    task automatic test_len_change();
        int s0;
        cycle(1'b0, 0, 0, 1'b1);
        window_len = 16'd4;
        s0 = strobe_count;
        for (int i = 0; i < 2; i++) cycle(1'b1, i, i, 1'b0);
        window_len = 16'd8;
        for (int i = 0; i < 2; i++) cycle(1'b1, i, i, 1'b0);
        checks++;
        if (peak_valid !== 1'b1) begin
            errors++;
            $display("FAIL len_change_first: peak_valid_o=%b required 1 after 4 samples", peak_valid);
        end
        for (int i = 0; i < 7; i++) cycle(1'b1, 50 + i, -50 - i, 1'b0);
        idle(1);
        checks++;
        if (strobe_count - s0 != 1) begin
            errors++;
            $display("FAIL len_change_early: got %0d strobes required 1", strobe_count - s0);
        end
        cycle(1'b1, 200, -300, 1'b0);
        idle(1);
        checks++;
        if (strobe_count - s0 != 2) begin
            errors++;
            $display("FAIL len_change_second: got %0d strobes required 2", strobe_count - s0);
        end
    endtask

    task automatic test_random_gaps();
        int s0;
        cycle(1'b0, 0, 0, 1'b1);
        window_len = 16'd5;
        s0 = strobe_count;
        for (int i = 0; i < 40; i++) begin
            idle(int'($urandom_range(0, 5)));
            cycle(1'b1, int'($urandom_range(0, 16383)) - 8192,
                  int'($urandom_range(0, 16383)) - 8192, 1'b0);
        end
        idle(1);
        checks++;
        if (strobe_count - s0 != 8) begin
            errors++;
            $display("FAIL random_gap_strobes: got %0d required 8", strobe_count - s0);
        end
    endtask

    task automatic test_clear();
        int   s0;
        exp_t held;
        held = last_exp;
        cycle(1'b0, 0, 0, 1'b1);
        window_len = 16'd8;
        s0 = strobe_count;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1000 * i, -1000 * i, 1'b0);
        cycle(1'b1, 7000, -7000, 1'b1);
        idle(2);
        checks++;
        if (strobe_count != s0) begin
            errors++;
            $display("FAIL clear_no_strobe: got %0d strobes required 0", strobe_count - s0);
        end
        checks++;
        if ({sin_max, sin_min, cos_max, cos_min, sin_amp, cos_amp, amp_delta} !== held) begin
            errors++;
            $display("FAIL clear_hold: got %h required %h",
                     {sin_max, sin_min, cos_max, cos_min, sin_amp, cos_amp, amp_delta}, held);
        end
        for (int i = 0; i < 8; i++) cycle(1'b1, 30 * i, -20 * i, 1'b0);
        idle(1);
        checks++;
        if (strobe_count - s0 != 1) begin
            errors++;
            $display("FAIL clear_restart: got %0d strobes required 1", strobe_count - s0);
        end
    endtask

    task automatic test_mismatch();
        logic [13:0] want_delta;
        cycle(1'b0, 0, 0, 1'b1);
        window_len = 16'd4;
        cycle(1'b1, 4000, 3000, 1'b0);
        cycle(1'b1, -4000, -3000, 1'b0);
        cycle(1'b1, 0, 0, 1'b0);
        cycle(1'b1, 0, 0, 1'b0);
        idle(1);
`ifdef PEAK_MISMATCH_EN
        want_delta = 14'd1000;
`else
        want_delta = 14'd0;
`endif
        checks++;
        if ({sin_amp, cos_amp, amp_delta} !== {14'd4000, 14'd3000, want_delta}) begin
            errors++;
            $display("FAIL mismatch: got samp=%0d camp=%0d delta=%0d required 4000 3000 %0d",
                     sin_amp, cos_amp, amp_delta, want_delta);
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b0, 0, 0, 1'b1);
        window_len = 16'd8;
        for (int i = 0; i < 3; i++) cycle(1'b1, 500, 600, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sin_max, sin_min, cos_max, cos_min, sin_amp, cos_amp, amp_delta, peak_valid} !== '0) begin
            errors++;
            $display("FAIL async_reset: got %h required 0",
                     {sin_max, sin_min, cos_max, cos_min, sin_amp, cos_amp, amp_delta, peak_valid});
        end
        model_reset();
        @(posedge clk);
        #1;
        idle(2);
        rst_n = 1'b1;
        window_len = 16'd2;
        cycle(1'b1, -10, 20, 1'b0);
        cycle(1'b1, 30, -40, 1'b0);
        idle(1);
        checks++;
        if ({sin_max, sin_min, cos_amp} !== {14'd30, 14'h3FF6, 14'd30}) begin
            errors++;
            $display("FAIL post_reset_window: got smax=%0d smin=%0d camp=%0d required 30 -10 30",
                     $signed(sin_max), $signed(sin_min), cos_amp);
        end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_full_scale();
        test_short_len();
        test_len_change();
        test_random_gaps();
        test_clear();
        test_mismatch();
        test_async_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results never strobed, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
